// File: rtl/alu_pipe_if.sv
// Issue/writeback handshake bundle for alu_pipe.
// slave is the ALU's view; master is the issue/consumer side.
interface alu_pipe_if #(
  parameter int N     = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [N-1:0]     op_a;
  logic [N-1:0]     op_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     result;
  logic [TAG_W-1:0] out_tag;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_ovf;
  logic             flag_err;

  modport master (
    output in_valid, opcode, op_a, op_b,
    output in_tag, out_ready,
    input  in_ready, out_valid, result,
    input  out_tag, flag_zero, flag_carry,
    input  flag_ovf, flag_err
  );

  modport slave (
    input  in_valid, opcode, op_a, op_b,
    input  in_tag, out_ready,
    output in_ready, out_valid, result,
    output out_tag, flag_zero, flag_carry,
    output flag_ovf, flag_err
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU: 1-cycle simple ops, N-cycle shift-add MUL,
// registered result/flags/tag held under backpressure.
module alu_pipe #(
  parameter int N     = 32,
  parameter int TAG_W = 4
) (
  input  logic     clk,
  input  logic     rst,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(N);

  typedef enum logic {IDLE, MUL} state_t;

  state_t state_q, state_d;

  logic             in_ready;
  logic             accept;
  logic             is_mul;
  logic             last_step;

  logic [N-1:0]     ma_q, mb_q, acc_q, acc_d;
  logic [SHW-1:0]   cnt_q;
  logic [TAG_W-1:0] mtag_q;

  logic             valid_q;
  logic [N-1:0]     res_q;
  logic [TAG_W-1:0] tag_q;
  logic             zero_q, carry_q;
  logic             ovf_q, err_q;

  logic [N-1:0]     a, b;
  logic [N:0]       sum, diff;
  logic [SHW-1:0]   sh;
  logic [N-1:0]     alu_res;
  logic             alu_c, alu_v, alu_e;

  assign a = bus.op_a;
  assign b = bus.op_b;

  assign in_ready = !rst && (state_q == IDLE)
                    && (!valid_q || bus.out_ready);
  assign accept = bus.in_valid && in_ready;
  assign is_mul = bus.opcode == 4'd12;

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    sh      = b[SHW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_e   = 1'b0;
    case (bus.opcode)
      4'd0: begin
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_v   = (a[N-1] == b[N-1])
                  && (sum[N-1] != a[N-1]);
      end
      4'd1: alu_res = {{(N-1){1'b0}}, a < b};
      4'd2: alu_res = {{(N-1){1'b0}}, a == b};
      4'd3: alu_res = a | b;
      4'd4: alu_res = a & b;
      4'd5: alu_res = ~a;
      4'd6: begin
        // diff[N] is the borrow: set exactly when a < b unsigned
        alu_res = diff[N-1:0];
        alu_c   = diff[N];
        alu_v   = (a[N-1] != b[N-1])
                  && (diff[N-1] != a[N-1]);
      end
      4'd7: alu_res = a ^ b;
      4'd8: alu_res = {{(N-1){1'b0}},
                       $signed(a) < $signed(b)};
      4'd9:  alu_res = a << sh;
      4'd10: alu_res = a >> sh;
      4'd11: alu_res = $signed(a) >>> sh;
      4'd12: alu_res = '0;
      default: alu_e = 1'b1;
    endcase
  end

  assign acc_d     = acc_q + (mb_q[0] ? ma_q : '0);
  assign last_step = cnt_q == SHW'(N - 1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && is_mul) state_d = MUL;
      MUL:  if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      tag_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      mtag_q  <= '0;
    end else if (state_q == MUL) begin
      acc_q <= acc_d;
      ma_q  <= ma_q << 1;
      mb_q  <= mb_q >> 1;
      cnt_q <= cnt_q + 1'b1;
      if (last_step) begin
        valid_q <= 1'b1;
        res_q   <= acc_d;
        tag_q   <= mtag_q;
        zero_q  <= acc_d == '0;
        carry_q <= 1'b0;
        ovf_q   <= 1'b0;
        err_q   <= 1'b0;
      end
    end else if (accept && is_mul) begin
      // previous result was consumed this edge
      valid_q <= 1'b0;
      ma_q    <= a;
      mb_q    <= b;
      acc_q   <= '0;
      cnt_q   <= '0;
      mtag_q  <= bus.in_tag;
    end else if (accept) begin
      valid_q <= 1'b1;
      res_q   <= alu_res;
      tag_q   <= bus.in_tag;
      zero_q  <= alu_res == '0;
      carry_q <= alu_c;
      ovf_q   <= alu_v;
      err_q   <= alu_e;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = valid_q;
  assign bus.result     = res_q;
  assign bus.out_tag    = tag_q;
  assign bus.flag_zero  = zero_q;
  assign bus.flag_carry = carry_q;
  assign bus.flag_ovf   = ovf_q;
  assign bus.flag_err   = err_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at N=8, TAG_W=4.
// Drives on falling edges, checks on falling edges.
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_pipe_if #(.N(8), .TAG_W(4)) bus();

  alu_pipe #(.N(8), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [3:0] t);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.in_tag   = t;
  endtask

  function automatic logic [7:0] model(
    input logic [3:0] op,
    input logic [7:0] a,
    input logic [7:0] b);
    logic [7:0] r;
    logic [2:0] s;
    s = b[2:0];
    r = 8'h00;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = (a < b) ? 8'd1 : 8'd0;
      4'd2:  r = (a == b) ? 8'd1 : 8'd0;
      4'd3:  r = a | b;
      4'd4:  r = a & b;
      4'd5:  r = ~a;
      4'd6:  r = a - b;
      4'd7:  r = a ^ b;
      4'd8:  r = ((a ^ 8'h80) < (b ^ 8'h80))
                 ? 8'd1 : 8'd0;
      4'd9:  r = a << s;
      4'd10: r = a >> s;
      4'd11: begin
        r = a;
        for (int k = 0; k < 8; k++)
          if (k < int'(s)) r = {r[7], r[7:1]};
      end
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic seen, stable;
    logic [3:0] op;
    logic [7:0] ra, rb;

    bus.in_valid  = 1'b0;
    bus.opcode    = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    tick; tick;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", bus.in_ready, 1);

    // ADD wrap
    drive(4'd0, 8'hFF, 8'h01, 4'd3);
    tick;
    bus.in_valid = 1'b0;
    chk("add_valid", bus.out_valid, 1);
    chk("add_res", bus.result, 8'h00);
    chk("add_carry", bus.flag_carry, 1);
    chk("add_zero", bus.flag_zero, 1);
    chk("add_ovf", bus.flag_ovf, 0);
    chk("add_tag", bus.out_tag, 3);
    tick;
    chk("add_drop", bus.out_valid, 0);

    drive(4'd6, 8'h80, 8'h01, 4'd4);
    tick;
    chk("sub_res", bus.result, 8'h7F);
    chk("sub_ovf", bus.flag_ovf, 1);
    chk("sub_carry", bus.flag_carry, 0);
    drive(4'd6, 8'h01, 8'h02, 4'd4);
    tick;
    chk("sub_borrow", bus.flag_carry, 1);
    drive(4'd1, 8'hFF, 8'h01, 4'd4);
    tick;
    chk("less_res", bus.result, 0);
    drive(4'd8, 8'hFF, 8'h01, 4'd4);
    tick;
    chk("slt_res", bus.result, 1);
    drive(4'd11, 8'h90, 8'hF2, 4'd4);
    tick;
    bus.in_valid = 1'b0;
    chk("sra_res", bus.result, 8'hE4);
    chk("sra_carry", bus.flag_carry, 0);
    tick;

    // MUL 13*11
    drive(4'd12, 8'd13, 8'd11, 4'd2);
    tick;
    bus.in_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!bus.out_valid && n < 20) begin
      if (bus.in_ready) seen = 1'b1;
      tick;
      n++;
    end
    chk("mul_latency", n, 8);
    chk("mul_ready_low", seen, 0);
    chk("mul_res", bus.result, 8'h8F);
    chk("mul_tag", bus.out_tag, 2);

    drive(4'd12, 8'hFF, 8'hFF, 4'd5);
    tick;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick;
      n++;
    end
    chk("mul2_latency", n, 8);
    chk("mul2_res", bus.result, 8'h01);
    chk("mul2_zero", bus.flag_zero, 0);
    tick;

    // backpressure
    bus.out_ready = 1'b0;
    drive(4'd0, 8'h05, 8'h03, 4'd5);
    tick;
    drive(4'd7, 8'hAA, 8'h0F, 4'd6);
    #1;
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_res", bus.result, 8'h08);
    chk("bp_ready", bus.in_ready, 0);
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (bus.result !== 8'h08 || bus.out_tag !== 4'd5
          || bus.out_valid !== 1'b1
          || bus.flag_zero !== 1'b0
          || bus.in_ready !== 1'b0)
        stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", bus.in_ready, 1);
    tick;
    bus.in_valid = 1'b0;
    chk("b2b_valid", bus.out_valid, 1);
    chk("b2b_res", bus.result, 8'hA5);
    chk("b2b_tag", bus.out_tag, 6);
    tick;
    chk("b2b_drop", bus.out_valid, 0);

    // reset mid-MUL
    drive(4'd12, 8'd3, 8'd3, 4'd9);
    tick;
    bus.in_valid = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    #1 chk("rst_mul_ready", bus.in_ready, 0);
    tick;
    chk("rst_mul_valid", bus.out_valid, 0);
    chk("rst_mul_res", bus.result, 0);
    rst = 1'b0;
    #1 chk("rst_mul_ready1", bus.in_ready, 1);
    drive(4'd0, 8'd2, 8'd2, 4'd1);
    tick;
    bus.in_valid = 1'b0;
    chk("post_rst_res", bus.result, 4);
    chk("post_rst_tag", bus.out_tag, 1);
    chk("post_rst_valid", bus.out_valid, 1);
    n = 0;
    seen = 1'b0;
    while (n < 12) begin
      tick;
      if (bus.out_valid) seen = 1'b1;
      n++;
    end
    chk("no_stale_mul", seen, 0);

    // illegal opcode
    drive(4'd14, 8'h12, 8'h34, 4'd7);
    tick;
    bus.in_valid = 1'b0;
    chk("ill_res", bus.result, 0);
    chk("ill_err", bus.flag_err, 1);
    chk("ill_zero", bus.flag_zero, 1);
    chk("ill_carry", bus.flag_carry, 0);
    chk("ill_tag", bus.out_tag, 7);
    tick;

    // back-to-back stream
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(0, 11));
      ra = 8'($urandom);
      rb = 8'($urandom);
      drive(op, ra, rb, 4'(i));
      #1 if (!bus.in_ready) seen = 1'b1;
      tick;
      chk($sformatf("stream%0d_res", i),
          {bus.out_valid, bus.out_tag, bus.result},
          {1'b1, 4'(i), model(op, ra, rb)});
    end
    bus.in_valid = 1'b0;
    chk("stream_ready", seen, 0);
    tick;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, handshaked successor to the team's combinational ALU. It keeps opcodes 0-5 bit-compatible and adds SUB, XOR, signed compare, shifts and an iterative multiply. It also adds status flags, a registered output with valid/ready backpressure, and a tag passthrough. It sits between the decode/issue stage and writeback, one operation in flight at a time.

Parameters:
N, 32, operand/result width (>=4, power of two).
TAG_W, 4, width of the caller tag carried with each operation.
SHW (localparam), $clog2(N), shift-amount width taken from op_b[SHW-1:0].

Ports:
clk  input  1  single clock, all state on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operation present on opcode/op_a/op_b/in_tag.
in_ready  output  1  block can accept an operation this cycle.
opcode  input  4  operation select.
op_a  input  N  first operand.
op_b  input  N  second operand / shift amount.
in_tag  input  TAG_W  caller tag, returned unchanged.
out_valid  output  1  result/flags/out_tag valid.
out_ready  input  1  consumer accepts result this cycle.
result  output  N  operation result.
out_tag  output  TAG_W  tag of the operation producing result.
flag_zero  output  1  result == 0.
flag_carry  output  1  ADD: carry-out; SUB: borrow (op_a < op_b unsigned); else 0.
flag_ovf  output  1  ADD/SUB signed overflow; else 0.
flag_err  output  1  illegal opcode.

Behaviour:
- Opcodes: 0 ADD, 1 LESS (unsigned, result 0/1 zero-extended), 2 EQ (0/1), 3 OR, 4 AND, 5 NOT (~op_a), 6 SUB, 7 XOR, 8 SLT (signed, 0/1), 9 SLL, 10 SRL, 11 SRA, 12 MUL (low N bits of unsigned product), 13-15 illegal -> result 0, flag_err 1, other flags 0 except flag_zero 1.
- Arithmetic is modulo 2^N. ADD/SUB use an N+1-bit sum for carry/borrow. Overflow occurs when the operand signs give a result of wrong sign (SUB: sign(a)!=sign(b) and sign(r)!=sign(a)).
- Shift amount is op_b[SHW-1:0]; upper op_b bits are ignored. SRA replicates op_a[N-1].
- Accept: handshake at a rising edge where in_valid && in_ready. Inputs are sampled only then and may change afterwards.
- FSM states:
  - IDLE: in_ready = !out_valid || out_ready. Simple op accepted -> result/flags/out_tag registered at that edge, out_valid 1 after it (latency 1). MUL accepted -> latch operands and tag, clear accumulator and counter -> MUL.
  - MUL: in_ready 0. One shift-add step per cycle, N steps. At the Nth step's edge the product is written to result, out_valid goes 1, and the FSM returns to IDLE. out_valid rises N edges after the accept edge.
- Output hold: while out_valid && !out_ready, result/flags/out_tag are stable and no new op is accepted.
- out_valid clears on an edge with out_ready, unless a new simple op is accepted on the same edge. In that case the new result replaces the old one and out_valid stays 1 (back-to-back, full throughput for simple ops).
- A MUL accepted while a previous result is being consumed: out_valid drops at the accept edge and stays 0 until MUL completes.
- Reset (any state, including mid-MUL): FSM to IDLE; out_valid, result, out_tag and all flags go to 0; the in-flight MUL is discarded. in_ready is 0 while rst is 1.
- in_valid with in_ready 0 has no effect. The source must hold its request; the block does not buffer.

Test Plan:
- N=8, ADD 0xFF+0x01 tag 3 -> result 0x00, carry 1, zero 1, ovf 0, out_tag 3, out_valid one cycle after accept.
- N=8, SUB 0x80-0x01 -> 0x7F, ovf 1, carry 0. Then LESS 0xFF,0x01 -> 0 and SLT 0xFF,0x01 -> 1. SRA 0x90 by op_b=0xF2 -> 0xE4.
- N=8, MUL 13*11 -> 0x8F, out_valid exactly 8 edges after accept, in_ready 0 throughout. MUL 0xFF*0xFF -> 0x01.
- Backpressure: out_ready low 3 cycles after an ADD -> result, flags and tag stable, in_ready 0. Raise out_ready while a second op is waiting -> second op accepted that edge, out_valid stays high, and the next result appears.
- Assert rst on the 4th cycle of a MUL -> next cycle out_valid 0, result 0, in_ready 1 after rst drops. A new ADD completes normally.
- Opcode 14 -> result 0, flag_err 1, flag_zero 1. Back-to-back stream of 16 random simple ops with out_ready=1 -> one result per cycle, matching a reference model in order.
